// File: rtl/alut_pkg13.sv
// Shared types and entry layout for the ALUT address lookup/learn engine.
// Entry: [82] valid, [81:50] last-accessed time, [49:48] port, [47:0] MAC.
package alut_pkg13;

    typedef enum logic [3:0] {
        IDLE,
        DST_RD,
        DST_CHK,
        AGE_REQ,
        AGE_WAIT,
        SRC_RD,
        SRC_CHK,
        SRC_WR,
        DONE
    } alut_state_e;

    localparam int ENTRY_W   = 83;
    localparam int VALID_BIT = 82;
    localparam int TIME_HI   = 81;
    localparam int TIME_LO   = 50;
    localparam int PORT_HI   = 49;
    localparam int PORT_LO   = 48;
    localparam int MAC_HI    = 47;
    localparam int MAC_LO    = 0;
    // Individual/group bit of a MAC address; group sources are never learned.
    localparam int GROUP_BIT = 40;

    localparam logic [7:0] MAX_ADDR = 8'hff;

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [31:0] stamp,
                                                      input logic [1:0]  port,
                                                      input logic [47:0] mac);
        return {1'b1, stamp, port, mac};
    endfunction

endpackage

// File: rtl/alut_hash13.sv
// Combinational 48->8 hash: XOR fold of the six address bytes.
module alut_hash13 (
    input  logic [47:0] addr_i,
    output logic [7:0]  index_o
);

    assign index_o = addr_i[47:40] ^ addr_i[39:32] ^ addr_i[31:24] ^
                     addr_i[23:16] ^ addr_i[15:8]  ^ addr_i[7:0];

endmodule

// File: rtl/alut_addr_lookup13.sv
// Per-frame destination lookup and source learning engine for the ALUT.
// Reads the destination entry, checks its age, then learns the source entry.
module alut_addr_lookup13
    import alut_pkg13::*;
#(
    parameter int AGE_TMO = 16
) (
    input  logic                pclk13,
    input  logic                p_reset13,
    input  logic                req13,
    input  logic [47:0]         d_addr13,
    input  logic [47:0]         s_addr13,
    input  logic [1:0]          s_port13,
    output logic                rdy13,
    output logic                lookup_done13,
    output logic                lookup_hit13,
    output logic [1:0]          lookup_port13,
    output logic [7:0]          coll_cnt13,
    output logic                age_tmo_err13,
    output logic [7:0]          mem_addr_add13,
    output logic                mem_write_add13,
    output logic [ENTRY_W-1:0]  mem_write_data_add13,
    input  logic [ENTRY_W-1:0]  mem_read_data_add13,
    output logic                check_age13,
    output logic [31:0]         last_accessed13,
    output logic                add_check_active13,
    input  logic                age_confirmed13,
    input  logic                age_ok13,
    input  logic [31:0]         curr_time13,
    input  logic                age_check_active13
);

    localparam int CNT_W = (AGE_TMO > 1) ? $clog2(AGE_TMO) : 1;

    alut_state_e      state_q, state_d;
    logic [47:0]      d_addr_q, d_addr_d;
    logic [47:0]      s_addr_q, s_addr_d;
    logic [1:0]       s_port_q, s_port_d;
    logic [31:0]      dst_time_q, dst_time_d;
    logic [1:0]       dst_port_q, dst_port_d;
    logic             hit_q, hit_d;
    logic [1:0]       port_q, port_d;
    logic [7:0]       coll_q, coll_d;
    logic             tmo_err_q, tmo_err_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [47:0]      hash_in;
    logic [7:0]       hash_idx;
    logic             accept;
    logic             rd_valid;
    logic [47:0]      rd_mac;

    // A single hash unit is shared: destination during DST_RD, source otherwise.
    assign hash_in = (state_q == DST_RD) ? d_addr_q : s_addr_q;

    alut_hash13 u_hash (
        .addr_i  (hash_in),
        .index_o (hash_idx)
    );

    assign rdy13    = (state_q == IDLE) & ~age_check_active13;
    assign accept   = req13 & rdy13;
    assign rd_valid = mem_read_data_add13[VALID_BIT];
    assign rd_mac   = mem_read_data_add13[MAC_HI:MAC_LO];

    always_comb begin
        state_d    = state_q;
        d_addr_d   = d_addr_q;
        s_addr_d   = s_addr_q;
        s_port_d   = s_port_q;
        dst_time_d = dst_time_q;
        dst_port_d = dst_port_q;
        hit_d      = hit_q;
        port_d     = port_q;
        coll_d     = coll_q;
        tmo_err_d  = tmo_err_q;
        tmo_cnt_d  = tmo_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    d_addr_d = d_addr13;
                    s_addr_d = s_addr13;
                    s_port_d = s_port13;
                    hit_d    = 1'b0;
                    port_d   = 2'b00;
                    state_d  = DST_RD;
                end
            end
            DST_RD: state_d = DST_CHK;
            DST_CHK: begin
                dst_time_d = mem_read_data_add13[TIME_HI:TIME_LO];
                dst_port_d = mem_read_data_add13[PORT_HI:PORT_LO];
                if (rd_valid && (rd_mac == d_addr_q)) begin
                    state_d = AGE_REQ;
                end else begin
                    hit_d   = 1'b0;
                    port_d  = 2'b00;
                    state_d = SRC_RD;
                end
            end
            AGE_REQ: begin
                tmo_cnt_d = '0;
                state_d   = AGE_WAIT;
            end
            AGE_WAIT: begin
                // A stale entry is only reported as a miss; the learn path may replace it.
                if (age_confirmed13) begin
                    hit_d   = age_ok13;
                    port_d  = age_ok13 ? dst_port_q : 2'b00;
                    state_d = SRC_RD;
                end else if (tmo_cnt_q == CNT_W'(AGE_TMO - 1)) begin
                    hit_d     = 1'b0;
                    port_d    = 2'b00;
                    tmo_err_d = 1'b1;
                    state_d   = SRC_RD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            SRC_RD: state_d = SRC_CHK;
            SRC_CHK: begin
                if (s_addr_q[GROUP_BIT]) begin
                    state_d = DONE;
                end else begin
                    if (rd_valid && (rd_mac != s_addr_q) && (coll_q != MAX_ADDR)) begin
                        coll_d = coll_q + 8'd1;
                    end
                    state_d = SRC_WR;
                end
            end
            SRC_WR:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk13) begin
        if (p_reset13) begin
            state_q    <= IDLE;
            d_addr_q   <= '0;
            s_addr_q   <= '0;
            s_port_q   <= '0;
            dst_time_q <= '0;
            dst_port_q <= '0;
            hit_q      <= 1'b0;
            port_q     <= '0;
            coll_q     <= '0;
            tmo_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            d_addr_q   <= d_addr_d;
            s_addr_q   <= s_addr_d;
            s_port_q   <= s_port_d;
            dst_time_q <= dst_time_d;
            dst_port_q <= dst_port_d;
            hit_q      <= hit_d;
            port_q     <= port_d;
            coll_q     <= coll_d;
            tmo_err_q  <= tmo_err_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    always_comb begin
        mem_addr_add13       = 8'h00;
        mem_write_add13      = 1'b0;
        mem_write_data_add13 = '0;
        check_age13          = 1'b0;
        last_accessed13      = 32'h0;

        unique case (state_q)
            DST_RD, SRC_RD: mem_addr_add13 = hash_idx;
            SRC_WR: begin
                mem_addr_add13       = hash_idx;
                mem_write_add13      = 1'b1;
                mem_write_data_add13 = make_entry(curr_time13, s_port_q, s_addr_q);
            end
            AGE_REQ: begin
                check_age13     = 1'b1;
                last_accessed13 = dst_time_q;
            end
            AGE_WAIT: last_accessed13 = dst_time_q;
            default: ;
        endcase
    end

    assign lookup_done13      = (state_q == DONE);
    assign lookup_hit13       = hit_q;
    assign lookup_port13      = port_q;
    assign coll_cnt13         = coll_q;
    assign age_tmo_err13      = tmo_err_q;
    assign add_check_active13 = (state_q != IDLE);

endmodule

// File: tb/tb_alut_addr_lookup13.sv
// Self-checking bench for alut_addr_lookup13: table vectors, random requests
// against a reference model, plus saturation, reset and ready-gating sequences.
module tb_alut_addr_lookup13;

    logic        pclk13 = 1'b0;
    logic        p_reset13;
    logic        req13;
    logic [47:0] d_addr13, s_addr13;
    logic [1:0]  s_port13;
    logic        rdy13, lookup_done13, lookup_hit13;
    logic [1:0]  lookup_port13;
    logic [7:0]  coll_cnt13;
    logic        age_tmo_err13;
    logic [7:0]  mem_addr_add13;
    logic        mem_write_add13;
    logic [82:0] mem_write_data_add13, mem_read_data_add13;
    logic        check_age13;
    logic [31:0] last_accessed13;
    logic        add_check_active13;
    logic        age_confirmed13, age_ok13;
    logic [31:0] curr_time13;
    logic        age_check_active13;

    always #5 pclk13 = ~pclk13;

    alut_addr_lookup13 #(.AGE_TMO(16)) dut (
        .pclk13(pclk13), .p_reset13(p_reset13), .req13(req13),
        .d_addr13(d_addr13), .s_addr13(s_addr13), .s_port13(s_port13),
        .rdy13(rdy13), .lookup_done13(lookup_done13), .lookup_hit13(lookup_hit13),
        .lookup_port13(lookup_port13), .coll_cnt13(coll_cnt13),
        .age_tmo_err13(age_tmo_err13), .mem_addr_add13(mem_addr_add13),
        .mem_write_add13(mem_write_add13), .mem_write_data_add13(mem_write_data_add13),
        .mem_read_data_add13(mem_read_data_add13), .check_age13(check_age13),
        .last_accessed13(last_accessed13), .add_check_active13(add_check_active13),
        .age_confirmed13(age_confirmed13), .age_ok13(age_ok13),
        .curr_time13(curr_time13), .age_check_active13(age_check_active13)
    );

    // ALUT memory with one-cycle read latency and a back door for preloading.
    logic [82:0] mem [256];
    logic [82:0] rdata;
    int          wr_cnt = 0;
    logic        bench_we = 1'b0;
    logic [7:0]  bench_addr = 8'h00;
    logic [82:0] bench_data = '0;

    always @(posedge pclk13) begin
        if (bench_we) mem[bench_addr] <= bench_data;
        else if (mem_write_add13) begin
            mem[mem_addr_add13] <= mem_write_data_add13;
            wr_cnt <= wr_cnt + 1;
        end
        rdata <= mem[mem_addr_add13];
    end
    assign mem_read_data_add13 = rdata;

    // Age checker: answers two cycles after seeing a check request, when enabled.
    bit resp_en = 1'b1;
    bit resp_ok = 1'b1;
    initial begin
        age_confirmed13 = 1'b0;
        age_ok13        = 1'b0;
        forever begin
            @(negedge pclk13);
            if (check_age13 && resp_en) begin
                @(negedge pclk13);
                @(negedge pclk13);
                age_confirmed13 = 1'b1;
                age_ok13        = resp_ok;
                @(negedge pclk13);
                age_confirmed13 = 1'b0;
                age_ok13        = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    int total = 0;
    int bad   = 0;
    int coll_m = 0;
    bit tmo_m  = 1'b0;

    function automatic logic [7:0] hashf(input logic [47:0] a);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 6; i++) x ^= a[8*i +: 8];
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [82:0] act, input logic [82:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [82:0] e);
        @(negedge pclk13);
        bench_we   = 1'b1;
        bench_addr = a;
        bench_data = e;
        @(negedge pclk13);
        bench_we   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [47:0] d, input logic [47:0] s, input logic [1:0] p,
                                 input bit ok, input bit conf, input logic [31:0] t,
                                 input bit exp_hit, input logic [1:0] exp_port,
                                 input int exp_done, input bit exp_write);
        logic [82:0] dst, src;
        bit match;
        int done_k, chk_k, wr0, guard;
        dst   = mem[hashf(d)];
        src   = mem[hashf(s)];
        match = dst[82] && (dst[47:0] == d);
        if (match && !conf) tmo_m = 1'b1;
        if (!s[40] && src[82] && (src[47:0] != s) && coll_m < 255) coll_m++;
        resp_en     = conf;
        resp_ok     = ok;
        curr_time13 = t;
        wr0         = wr_cnt;
        guard       = 0;
        while (!rdy13 && guard < 20) begin
            @(negedge pclk13);
            guard++;
        end
        d_addr13 = d;
        s_addr13 = s;
        s_port13 = p;
        req13    = 1'b1;
        @(negedge pclk13);
        req13  = 1'b0;
        done_k = 0;
        chk_k  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (check_age13 && chk_k == 0) chk_k = k;
            if (lookup_done13) begin
                done_k = k;
                break;
            end
            @(negedge pclk13);
        end
        checkOutput("done_cycle", 83'(done_k), 83'(exp_done));
        checkOutput("hit", 83'(lookup_hit13), 83'(exp_hit));
        checkOutput("port", 83'(lookup_port13), 83'(exp_port));
        checkOutput("check_age_cycle", 83'(chk_k), match ? 83'd3 : 83'd0);
        checkOutput("coll_cnt", 83'(coll_cnt13), 83'(coll_m));
        checkOutput("age_tmo_err", 83'(age_tmo_err13), 83'(tmo_m));
        checkOutput("write_count", 83'(wr_cnt - wr0), exp_write ? 83'd1 : 83'd0);
        if (exp_write) checkOutput("learn_entry", mem[hashf(s)], {1'b1, t, p, s});
        resp_en = 1'b1;
    endtask

    typedef struct {
        logic [47:0] d;
        logic [47:0] s;
        logic [1:0]  p;
        bit          pre;
        logic [82:0] pre_e;
        bit          ok;
        bit          conf;
        bit          exp_hit;
        logic [1:0]  exp_port;
        int          exp_done;
        bit          exp_write;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [47:0] rd, rs;
        logic [82:0] e;
        bit rok, rmatch;
        int sel, wr0;

        vecs[0] = '{48'h0011_2233_4455, 48'h0011_2233_4455, 2'd2, 1'b0, 83'h0,
                    1'b1, 1'b1, 1'b0, 2'd0, 6, 1'b1};
        vecs[1] = '{48'h0A0B_0C0D_0E0F, 48'h0000_0000_0020, 2'd1, 1'b1,
                    {1'b1, 32'h100, 2'd3, 48'h0A0B_0C0D_0E0F},
                    1'b1, 1'b1, 1'b1, 2'd3, 9, 1'b1};
        vecs[2] = '{48'h0A0B_0C0D_0E0F, 48'h0000_0000_0021, 2'd0, 1'b1,
                    {1'b1, 32'h100, 2'd3, 48'h0A0B_0C0D_0E0F},
                    1'b0, 1'b1, 1'b0, 2'd0, 9, 1'b1};
        vecs[3] = '{48'h0000_0000_0077, 48'h0100_0000_0002, 2'd1, 1'b0, 83'h0,
                    1'b1, 1'b1, 1'b0, 2'd0, 5, 1'b0};
        vecs[4] = '{48'h0A0B_0C0D_0E0F, 48'h0000_0000_0030, 2'd2, 1'b1,
                    {1'b1, 32'h200, 2'd3, 48'h0A0B_0C0D_0E0F},
                    1'b1, 1'b0, 1'b0, 2'd0, 23, 1'b1};
        vecs[5] = '{48'h0000_0000_0077, 48'h0011_2233_5544, 2'd1, 1'b0, 83'h0,
                    1'b1, 1'b1, 1'b0, 2'd0, 6, 1'b1};

        p_reset13 = 1'b1;
        req13 = 1'b0;
        d_addr13 = '0;
        s_addr13 = '0;
        s_port13 = '0;
        curr_time13 = 32'h0;
        age_check_active13 = 1'b0;
        repeat (3) @(negedge pclk13);
        checkOutput("reset_done", 83'(lookup_done13), 83'd0);
        checkOutput("reset_hit", 83'(lookup_hit13), 83'd0);
        checkOutput("reset_port", 83'(lookup_port13), 83'd0);
        checkOutput("reset_coll", 83'(coll_cnt13), 83'd0);
        checkOutput("reset_tmo", 83'(age_tmo_err13), 83'd0);
        checkOutput("reset_we", 83'(mem_write_add13), 83'd0);
        checkOutput("reset_active", 83'(add_check_active13), 83'd0);
        p_reset13 = 1'b0;
        @(negedge pclk13);
        checkOutput("rdy_after_reset", 83'(rdy13), 83'd1);

        for (int a = 0; a < 256; a++) poke(8'(a), 83'h0);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre) poke(hashf(vecs[i].d), vecs[i].pre_e);
            applyStimulus(vecs[i].d, vecs[i].s, vecs[i].p, vecs[i].ok, vecs[i].conf,
                          32'h1000 + 32'(i), vecs[i].exp_hit, vecs[i].exp_port,
                          vecs[i].exp_done, vecs[i].exp_write);
        end
        checkOutput("stale_not_cleared", 83'(mem[8'h01][82]), 83'd1);

        $display("[TB] ready gating");
        @(negedge pclk13);
        age_check_active13 = 1'b1;
        @(negedge pclk13);
        checkOutput("rdy_blocked", 83'(rdy13), 83'd0);
        req13 = 1'b1;
        repeat (4) @(negedge pclk13);
        checkOutput("no_accept_blocked", 83'(add_check_active13), 83'd0);
        req13 = 1'b0;
        age_check_active13 = 1'b0;
        @(negedge pclk13);
        checkOutput("rdy_released", 83'(rdy13), 83'd1);

        $display("[TB] random requests");
        for (int i = 0; i < 40; i++) begin
            rd = {16'($urandom), $urandom};
            rs = {16'($urandom), $urandom};
            rs[40] = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            if (sel <= 1) poke(hashf(rd), {1'b1, $urandom, 2'($urandom), rd});
            else if (sel == 2) poke(hashf(rd), {1'b1, $urandom, 2'($urandom), rd ^ 48'h1});
            e      = mem[hashf(rd)];
            rmatch = e[82] && (e[47:0] == rd);
            rok    = 1'($urandom_range(0, 1));
            applyStimulus(rd, rs, 2'($urandom), rok, 1'b1, $urandom,
                          rmatch && rok, (rmatch && rok) ? e[49:48] : 2'd0,
                          (rmatch ? 9 : 6) - (rs[40] ? 1 : 0), !rs[40]);
        end

        $display("[TB] collision saturation");
        poke(8'h00, 83'h0);
        poke(8'h01, {1'b1, 32'h0, 2'd0, 48'h0000_0000_0100});
        for (int i = 0; i < 256; i++) begin
            applyStimulus(48'h0, (i % 2 == 0) ? 48'h0000_0000_0001 : 48'h0000_0000_0100,
                          2'd1, 1'b1, 1'b1, 32'(i), 1'b0, 2'd0, 6, 1'b1);
        end
        checkOutput("coll_saturated", 83'(coll_cnt13), 83'd255);

        $display("[TB] reset during age wait");
        poke(8'h01, {1'b1, 32'h300, 2'd2, 48'h0A0B_0C0D_0E0F});
        resp_en  = 1'b0;
        wr0      = wr_cnt;
        d_addr13 = 48'h0A0B_0C0D_0E0F;
        s_addr13 = 48'h0000_0000_0040;
        s_port13 = 2'd1;
        req13    = 1'b1;
        @(negedge pclk13);
        req13 = 1'b0;
        repeat (5) @(negedge pclk13);
        checkOutput("age_wait_last_accessed", 83'(last_accessed13), 83'h300);
        p_reset13 = 1'b1;
        @(negedge pclk13);
        checkOutput("mid_reset_active", 83'(add_check_active13), 83'd0);
        checkOutput("mid_reset_check_age", 83'(check_age13), 83'd0);
        checkOutput("mid_reset_we", 83'(mem_write_add13), 83'd0);
        checkOutput("mid_reset_wdata", mem_write_data_add13, 83'd0);
        checkOutput("mid_reset_addr", 83'(mem_addr_add13), 83'd0);
        checkOutput("mid_reset_last", 83'(last_accessed13), 83'd0);
        checkOutput("mid_reset_coll", 83'(coll_cnt13), 83'd0);
        checkOutput("mid_reset_tmo", 83'(age_tmo_err13), 83'd0);
        checkOutput("mid_reset_hit", 83'(lookup_hit13), 83'd0);
        checkOutput("mid_reset_done", 83'(lookup_done13), 83'd0);
        p_reset13 = 1'b0;
        coll_m = 0;
        tmo_m  = 1'b0;
        repeat (3) @(negedge pclk13);
        checkOutput("mid_reset_no_write", 83'(wr_cnt - wr0), 83'd0);
        resp_en = 1'b1;
        applyStimulus(48'h0000_0000_0077, 48'h0000_0000_0050, 2'd3, 1'b1, 1'b1,
                      32'h55, 1'b0, 2'd0, 6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
